ptp_rtc_counter: RTL and testbench

Free-running PTPv2 real-time clock that produces the time base consumed by the timestamp unit.
- Outputs: 48-bit seconds + 32-bit nanoseconds + 16-bit fractional nanoseconds.
- Advances by a programmable per-cycle increment, which is the frequency trim.
- Supports a direct time load (step) and a signed nanosecond offset adjustment (phase correction).
- Generates a 1PPS pulse of programmable width on each natural seconds rollover.

---
 rtl/ptp_rtc_counter_pkg.sv | 49 ++++
 rtl/ptp_rtc_counter_pps_gen.sv | 50 +++++
 rtl/ptp_rtc_counter.sv | 121 ++++++++++++
 tb/tb_ptp_rtc_counter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ptp_rtc_counter_pkg.sv
// Shared PTPv2 time-base definitions: field widths, nanosecond modulus and
// the normalisation helper used by the RTC accumulator.
package ptp_rtc_counter_pkg;

    localparam int SEC_W     = 48;
    localparam int NS_W      = 32;
    localparam int FNS_W     = 16;
    localparam int INCR_NS_W = 8;
    localparam int ACC_W     = 34;

    localparam int RTC_NS_PER_SEC = 1000000000;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2
    } sec_step_e;

    typedef enum logic {
        PPS_IDLE = 1'b0,
        PPS_HIGH = 1'b1
    } pps_state_e;

    typedef struct packed {
        logic [NS_W-1:0] ns;
        sec_step_e       step;
    } ns_norm_t;

    // The accumulator is bounded to (-modulus, 2*modulus), so a single add or
    // subtract of the modulus always lands back in [0, modulus).
    function automatic ns_norm_t normalise_ns(input logic signed [ACC_W-1:0] t,
                                              input logic signed [ACC_W-1:0] modulus);
        ns_norm_t                r;
        logic signed [ACC_W-1:0] v;
        if (t >= modulus) begin
            v      = t - modulus;
            r.step = STEP_UP;
        end else if (t[ACC_W-1]) begin
            v      = t + modulus;
            r.step = STEP_DOWN;
        end else begin
            v      = t;
            r.step = STEP_NONE;
        end
        r.ns = v[NS_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/ptp_rtc_counter_pps_gen.sv
// 1PPS pulse generator: a seconds tick starts (or restarts) a pulse that stays
// high for the programmed number of clock cycles.
module rtc_pps_gen
    import ptp_rtc_counter_pkg::*;
#(
    parameter int PPS_W_BITS = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sec_tick,
    input  logic [PPS_W_BITS-1:0] pps_width,
    output logic                  pps
);

    pps_state_e            state_q;
    logic [PPS_W_BITS-1:0] cnt_q;
    logic [PPS_W_BITS-1:0] width_eff;

    // A programmed width of zero still has to produce a visible pulse.
    assign width_eff = (pps_width == '0) ? PPS_W_BITS'(1) : pps_width;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PPS_IDLE;
            cnt_q   <= '0;
            pps     <= 1'b0;
        end else if (sec_tick) begin
            state_q <= PPS_HIGH;
            cnt_q   <= width_eff;
            pps     <= 1'b1;
        end else begin
            case (state_q)
                PPS_HIGH: begin
                    if (cnt_q <= PPS_W_BITS'(1)) begin
                        state_q <= PPS_IDLE;
                        cnt_q   <= '0;
                        pps     <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - PPS_W_BITS'(1);
                    end
                end
                default: begin
                    cnt_q <= '0;
                    pps   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ptp_rtc_counter.sv
// PTPv2 real-time clock: seconds / nanoseconds / fractional-ns accumulator with
// frequency trim, time step load, signed phase adjust and 1PPS output.
module ptp_rtc_counter
    import ptp_rtc_counter_pkg::*;
#(
    parameter int PPS_W_BITS = 24,
    parameter int NS_PER_SEC = RTC_NS_PER_SEC
) (
    input  logic                  rtc_clk,
    input  logic                  rtc_rst,
    input  logic                  rtc_en_i,
    input  logic [INCR_NS_W-1:0]  incr_ns_i,
    input  logic [FNS_W-1:0]      incr_fns_i,
    input  logic                  ld_i,
    input  logic [SEC_W-1:0]      ld_sec_i,
    input  logic [NS_W-1:0]       ld_ns_i,
    input  logic [FNS_W-1:0]      ld_fns_i,
    input  logic                  adj_i,
    input  logic [NS_W-1:0]       adj_ns_i,
    input  logic [PPS_W_BITS-1:0] pps_width_i,
    output logic [SEC_W+NS_W-1:0] rtc_std_o,
    output logic [FNS_W-1:0]      rtc_fns_o,
    output logic                  sec_tick_o,
    output logic                  pps_o,
    output logic                  cfg_err_o
);

    localparam logic signed [ACC_W-1:0] MOD_ACC = ACC_W'(NS_PER_SEC);
    localparam logic [NS_W-1:0]         MOD_NS  = NS_W'(NS_PER_SEC);

    logic [SEC_W-1:0] sec_q;
    logic [NS_W-1:0]  ns_q;
    logic [FNS_W-1:0] fns_q;
    logic             sec_tick_q;
    logic             cfg_err_q;

    logic                    ld_ok;
    logic                    ld_bad;
    logic                    adj_req;
    logic                    adj_ok;
    logic                    adj_bad;
    logic signed [ACC_W-1:0] adj_ext;
    logic [ACC_W-1:0]        adj_term;
    logic [ACC_W-1:0]        incr_term;
    logic [FNS_W:0]          fns_sum;
    logic signed [ACC_W-1:0] t_acc;
    ns_norm_t                norm;
    logic [SEC_W-1:0]        sec_nxt;

    assign ld_ok   = ld_i && (ld_ns_i < MOD_NS);
    assign ld_bad  = ld_i && !(ld_ns_i < MOD_NS);

    // A load in the same cycle always pre-empts the adjust, even a rejected load.
    assign adj_req = adj_i && !ld_i;
    assign adj_ext = ACC_W'(signed'(adj_ns_i));
    assign adj_ok  = (adj_ext > -MOD_ACC) && (adj_ext < MOD_ACC);
    assign adj_bad = adj_req && !adj_ok;

    always_comb begin
        fns_sum   = {1'b0, fns_q};
        incr_term = '0;
        adj_term  = '0;
        if (rtc_en_i) begin
            fns_sum   = {1'b0, fns_q} + {1'b0, incr_fns_i};
            incr_term = ACC_W'(incr_ns_i) + ACC_W'(fns_sum[FNS_W]);
        end
        if (adj_req && adj_ok) begin
            adj_term = adj_ext;
        end
        t_acc = ACC_W'(ns_q) + incr_term + adj_term;
    end

    assign norm = normalise_ns(t_acc, MOD_ACC);

    always_comb begin
        case (norm.step)
            STEP_UP:   sec_nxt = sec_q + SEC_W'(1);
            STEP_DOWN: sec_nxt = sec_q - SEC_W'(1);
            default:   sec_nxt = sec_q;
        endcase
    end

    always_ff @(posedge rtc_clk) begin
        if (rtc_rst) begin
            sec_q      <= '0;
            ns_q       <= '0;
            fns_q      <= '0;
            sec_tick_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q <= ld_bad || adj_bad;
            if (ld_ok) begin
                sec_q      <= ld_sec_i;
                ns_q       <= ld_ns_i;
                fns_q      <= ld_fns_i;
                sec_tick_q <= 1'b0;
            end else begin
                sec_q      <= sec_nxt;
                ns_q       <= norm.ns;
                fns_q      <= fns_sum[FNS_W-1:0];
                sec_tick_q <= (norm.step == STEP_UP);
            end
        end
    end

    rtc_pps_gen #(
        .PPS_W_BITS (PPS_W_BITS)
    ) u_pps_gen (
        .clk       (rtc_clk),
        .rst       (rtc_rst),
        .sec_tick  (sec_tick_q),
        .pps_width (pps_width_i),
        .pps       (pps_o)
    );

    assign rtc_std_o  = {sec_q, ns_q};
    assign rtc_fns_o  = fns_q;
    assign sec_tick_o = sec_tick_q;
    assign cfg_err_o  = cfg_err_q;

endmodule

// File: tb/tb_ptp_rtc_counter.sv
// Self-checking bench for ptp_rtc_counter: hand-derived vector table plus
// scoreboarded sequences for PPS width, restart and reset abort.
module tb_ptp_rtc_counter;

    localparam int PPS_W_BITS = 24;
    localparam logic [47:0] MAX_SEC = 48'hFFFF_FFFF_FFFF;

    logic        rtc_clk = 1'b0;
    logic        rtc_rst;
    logic        rtc_en_i;
    logic [7:0]  incr_ns_i;
    logic [15:0] incr_fns_i;
    logic        ld_i;
    logic [47:0] ld_sec_i;
    logic [31:0] ld_ns_i;
    logic [15:0] ld_fns_i;
    logic        adj_i;
    logic [31:0] adj_ns_i;
    logic [PPS_W_BITS-1:0] pps_width_i;
    logic [79:0] rtc_std_o;
    logic [15:0] rtc_fns_o;
    logic        sec_tick_o;
    logic        pps_o;
    logic        cfg_err_o;

    typedef struct {
        logic        rst;
        logic        en;
        logic [7:0]  incr_ns;
        logic [15:0] incr_fns;
        logic        ld;
        logic [47:0] ld_sec;
        logic [31:0] ld_ns;
        logic [15:0] ld_fns;
        logic        adj;
        logic [31:0] adj_ns;
        logic [47:0] exp_sec;
        logic [31:0] exp_ns;
        logic [15:0] exp_fns;
        logic        exp_tick;
        logic        exp_pps;
        logic        exp_err;
        string       tag;
    } vec_t;

    typedef struct {
        logic [47:0] sec;
        logic [31:0] ns;
        logic [15:0] fns;
        logic        tick;
        logic        pps;
        logic        err;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    ptp_rtc_counter #(
        .PPS_W_BITS (PPS_W_BITS),
        .NS_PER_SEC (1000000000)
    ) dut (
        .rtc_clk     (rtc_clk),
        .rtc_rst     (rtc_rst),
        .rtc_en_i    (rtc_en_i),
        .incr_ns_i   (incr_ns_i),
        .incr_fns_i  (incr_fns_i),
        .ld_i        (ld_i),
        .ld_sec_i    (ld_sec_i),
        .ld_ns_i     (ld_ns_i),
        .ld_fns_i    (ld_fns_i),
        .adj_i       (adj_i),
        .adj_ns_i    (adj_ns_i),
        .pps_width_i (pps_width_i),
        .rtc_std_o   (rtc_std_o),
        .rtc_fns_o   (rtc_fns_o),
        .sec_tick_o  (sec_tick_o),
        .pps_o       (pps_o),
        .cfg_err_o   (cfg_err_o)
    );

    always #5 rtc_clk = ~rtc_clk;

    function automatic vec_t mk(input logic rst, input logic en, input logic [7:0] incr_ns,
                                input logic [15:0] incr_fns, input logic ld, input logic [47:0] ld_sec,
                                input logic [31:0] ld_ns, input logic [15:0] ld_fns, input logic adj,
                                input logic [31:0] adj_ns, input logic [47:0] exp_sec,
                                input logic [31:0] exp_ns, input logic [15:0] exp_fns,
                                input logic exp_tick, input logic exp_pps, input logic exp_err,
                                input string tag);
        vec_t v;
        v.rst = rst;  v.en = en;  v.incr_ns = incr_ns;  v.incr_fns = incr_fns;
        v.ld = ld;  v.ld_sec = ld_sec;  v.ld_ns = ld_ns;  v.ld_fns = ld_fns;
        v.adj = adj;  v.adj_ns = adj_ns;
        v.exp_sec = exp_sec;  v.exp_ns = exp_ns;  v.exp_fns = exp_fns;
        v.exp_tick = exp_tick;  v.exp_pps = exp_pps;  v.exp_err = exp_err;
        v.tag = tag;
        return v;
    endfunction

    task automatic cmp(input string tag, input string field, input logic [63:0] got,
                       input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s.%s got=%0d want=%0d", tag, field, got, want);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_empty got=0 want=1");
        end else begin
            e = sb_q.pop_front();
            cmp(e.tag, "sec",  64'(rtc_std_o[79:32]), 64'(e.sec));
            cmp(e.tag, "ns",   64'(rtc_std_o[31:0]),  64'(e.ns));
            cmp(e.tag, "fns",  64'(rtc_fns_o),        64'(e.fns));
            cmp(e.tag, "tick", 64'(sec_tick_o),       64'(e.tick));
            cmp(e.tag, "pps",  64'(pps_o),            64'(e.pps));
            cmp(e.tag, "err",  64'(cfg_err_o),        64'(e.err));
        end
    endtask

    // Drives one cycle of inputs, queues what the outputs must show after the
    // next edge, then checks once that edge has passed.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        rtc_rst    = v.rst;
        rtc_en_i   = v.en;
        incr_ns_i  = v.incr_ns;
        incr_fns_i = v.incr_fns;
        ld_i       = v.ld;
        ld_sec_i   = v.ld_sec;
        ld_ns_i    = v.ld_ns;
        ld_fns_i   = v.ld_fns;
        adj_i      = v.adj;
        adj_ns_i   = v.adj_ns;
        e.sec  = v.exp_sec;  e.ns = v.exp_ns;  e.fns = v.exp_fns;
        e.tick = v.exp_tick; e.pps = v.exp_pps; e.err = v.exp_err;
        e.tag  = v.tag;
        sb_q.push_back(e);
        @(posedge rtc_clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rtc_rst = 1'b1;  rtc_en_i = 1'b0;  incr_ns_i = '0;  incr_fns_i = '0;
        ld_i = 1'b0;  ld_sec_i = '0;  ld_ns_i = '0;  ld_fns_i = '0;
        adj_i = 1'b0;  adj_ns_i = '0;  pps_width_i = 24'd3;
        @(posedge rtc_clk);
        #1;

        applyStimulus(mk(1,1,8'd6,16'h6666,0,0,0,0,0,0, 0,0,0, 0,0,0, "reset"));

        // 156.25 MHz trim: 6 ns + 0x6666/65536 ns per cycle from zero.
        for (int k = 1; k <= 10; k++) begin
            int prod;
            int fns_exp;
            int ns_exp;
            prod    = k * 26214;
            fns_exp = prod % 65536;
            ns_exp  = 6 * k + prod / 65536;
            applyStimulus(mk(0,1,8'd6,16'h6666,0,0,0,0,0,0,
                             48'd0, 32'(ns_exp), 16'(fns_exp), 0,0,0, $sformatf("incr%0d", k)));
        end

        tbl.push_back(mk(0,1,8'd8,0,1,48'd5,32'd999999990,0,0,0, 48'd5,32'd999999990,0, 0,0,0, "load5"));
        tbl.push_back(mk(0,1,8'd8,0,0,0,0,0,0,0,            48'd5,32'd999999998,0, 0,0,0, "run998"));
        tbl.push_back(mk(0,1,8'd8,0,0,0,0,0,0,0,            48'd6,32'd6,0,         1,0,0, "carry6"));
        tbl.push_back(mk(0,1,8'd8,0,0,0,0,0,0,0,            48'd6,32'd14,0,        0,1,0, "pps1"));
        tbl.push_back(mk(0,0,0,0,1,48'd10,32'd100,0,0,0,    48'd10,32'd100,0,      0,1,0, "load10"));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,32'hFFFF_FF38,   48'd9,32'd999999900,0, 0,1,0, "adjneg"));
        tbl.push_back(mk(0,1,8'd8,0,1,48'd1,32'd1000000000,0,0,0, 48'd9,32'd999999908,0, 0,0,1, "ldbad"));
        tbl.push_back(mk(0,1,8'd8,0,0,0,0,0,1,32'h3B9A_CA00, 48'd9,32'd999999916,0, 0,0,1, "adjbadpos"));
        tbl.push_back(mk(0,1,8'd8,0,0,0,0,0,1,32'hC465_3600, 48'd9,32'd999999924,0, 0,0,1, "adjbadneg"));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,32'h3B9A_C9FF,   48'd10,32'd999999923,0, 1,0,0, "adjpos"));
        tbl.push_back(mk(0,0,0,0,1,48'd0,32'd0,0,1,32'd50,  48'd0,32'd0,0,         0,1,0, "ldadj"));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,32'hFFFF_FFFF,   MAX_SEC,32'd999999999,0, 0,1,0, "secunder"));
        tbl.push_back(mk(0,1,0,16'd1,1,MAX_SEC,32'd999999999,16'hFFFF,0,0,
                         MAX_SEC,32'd999999999,16'hFFFF, 0,1,0, "ldmax"));
        tbl.push_back(mk(0,1,0,16'd1,0,0,0,0,0,0,           48'd0,32'd0,16'd0,     1,0,0, "wrap"));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,               48'd0,32'd0,16'd0,     0,1,0, "hold"));
        tbl.push_back(mk(1,1,8'd8,0,0,0,0,0,0,0,            48'd0,32'd0,16'd0,     0,0,0, "rstpps"));

        foreach (tbl[i]) applyStimulus(tbl[i]);

        // Zero width still yields a one-cycle pulse.
        pps_width_i = 24'd0;
        applyStimulus(mk(0,0,0,0,1,48'd7,32'd999999999,0,0,0, 48'd7,32'd999999999,0, 0,0,0, "w0load"));
        applyStimulus(mk(0,1,8'd1,0,0,0,0,0,0,0,              48'd8,32'd0,0,         1,0,0, "w0tick"));
        applyStimulus(mk(0,0,0,0,0,0,0,0,0,0,                 48'd8,32'd0,0,         0,1,0, "w0high"));
        applyStimulus(mk(0,0,0,0,0,0,0,0,0,0,                 48'd8,32'd0,0,         0,0,0, "w0low"));

        // A second tick while the pulse is high restarts the width count.
        pps_width_i = 24'd2;
        applyStimulus(mk(0,0,0,0,1,48'd8,32'd999999999,0,0,0, 48'd8,32'd999999999,0, 0,0,0, "rsload"));
        applyStimulus(mk(0,1,8'd1,0,0,0,0,0,0,0,              48'd9,32'd0,0,         1,0,0, "rstick1"));
        applyStimulus(mk(0,0,0,0,1'b0,0,0,0,1,32'h3B9A_C9FF,  48'd9,32'd999999999,0, 0,1,0, "rsadj"));
        applyStimulus(mk(0,1,8'd1,0,0,0,0,0,0,0,              48'd10,32'd0,0,        1,1,0, "rstick2"));
        applyStimulus(mk(0,0,0,0,0,0,0,0,0,0,                 48'd10,32'd0,0,        0,1,0, "rsrestart"));
        applyStimulus(mk(0,0,0,0,0,0,0,0,0,0,                 48'd10,32'd0,0,        0,1,0, "rsstill"));
        applyStimulus(mk(0,0,0,0,0,0,0,0,0,0,                 48'd10,32'd0,0,        0,0,0, "rsdrop"));

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_left got=%0d want=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
